// File: rtl/seg_ctrl_pkg.sv
// Shared encodings and defaults for the seven-segment display control blocks.
package seg_ctrl_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_SHOW = 1'b1;

    localparam logic MODE_OFF = 1'b0;
    localparam logic MODE_HEX = 1'b1;

    // One second of dwell at a 100 MHz system clock.
    localparam int DWELL_DEFAULT = 100_000_000;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set mask bit searching upward from ptr+1, wrapping,
// so the entry at ptr itself is considered last.
module rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] mask,
    input  logic [2:0]      ptr,
    output logic [NREQ-1:0] gnt,
    output logic [2:0]      idx,
    output logic            vld
);

    logic [7:0]      mask8_s;
    logic [2:0]      pos_s;
    logic [2:0]      idx_s;
    logic            vld_s;
    logic [NREQ-1:0] gnt_s;

    assign mask8_s = 8'(mask);

    // Walk the NREQ candidate positions in priority order and keep the first hit.
    always_comb begin
        idx_s = 3'd0;
        vld_s = 1'b0;
        pos_s = 3'd0;
        for (int k = 1; k <= NREQ; k++) begin
            pos_s = 3'((32'(ptr) + 32'(k)) % 32'(NREQ));
            if (!vld_s && mask8_s[pos_s]) begin
                idx_s = pos_s;
                vld_s = 1'b1;
            end else begin
                vld_s = vld_s;
            end
        end
    end

    // One-hot form of the chosen index.
    always_comb begin
        gnt_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt_s[i] = vld_s && (idx_s == 3'(i));
        end
    end

    assign gnt = gnt_s;
    assign idx = idx_s;
    assign vld = vld_s;

endmodule

// File: rtl/seg_display_arbiter.sv
// Time-shares the 8-digit display between NREQ requesters: round-robin with
// urgent preemption, value latched at grant and held for the dwell period.
module seg_display_arbiter
    import seg_ctrl_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int CNT_W = 27,
    parameter int DWELL = DWELL_DEFAULT
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [NREQ-1:0]      REQ,
    input  logic [NREQ-1:0]      URG,
    input  logic [32*NREQ-1:0]   VAL,
    output logic [31:0]          HEX,
    output logic                 display_mode,
    output logic [NREQ-1:0]      GNT,
    output logic [2:0]           OWNER,
    output logic                 ACK
);

    logic             state_r, state_nxt_s;
    logic [2:0]       owner_r, owner_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic [31:0]      hex_r, hex_nxt_s;
    logic             mode_r, mode_nxt_s;
    logic [NREQ-1:0]  gnt_r, gnt_nxt_s;
    logic             ack_r, ack_nxt_s;

    logic [NREQ-1:0]  urg_mask_s;
    logic [NREQ-1:0]  u_gnt_s, f_gnt_s, win_gnt_s;
    logic [2:0]       u_idx_s, f_idx_s, win_idx_s;
    logic             u_vld_s, f_vld_s;
    logic [31:0]      win_val_s;
    logic [7:0]       req8_s, urg8_s;
    logic             rearb_s;

    assign urg_mask_s = REQ & URG;
    assign req8_s     = 8'(REQ);
    assign urg8_s     = 8'(URG);

    rr_pick #(.NREQ(NREQ)) u_pick_urg (
        .mask (urg_mask_s),
        .ptr  (owner_r),
        .gnt  (u_gnt_s),
        .idx  (u_idx_s),
        .vld  (u_vld_s)
    );

    rr_pick #(.NREQ(NREQ)) u_pick_all (
        .mask (REQ),
        .ptr  (owner_r),
        .gnt  (f_gnt_s),
        .idx  (f_idx_s),
        .vld  (f_vld_s)
    );

    assign win_gnt_s = u_vld_s ? u_gnt_s : f_gnt_s;
    assign win_idx_s = u_vld_s ? u_idx_s : f_idx_s;

    // Urgent traffic only displaces a non-urgent owner; expiry and drop always do.
    assign rearb_s = (cnt_r == CNT_W'(DWELL - 1))
                   || !req8_s[owner_r]
                   || (u_vld_s && !urg8_s[owner_r]);

    // Select the winner's display word.
    always_comb begin
        win_val_s = 32'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx_s == 3'(i)) begin
                win_val_s = VAL[32*i +: 32];
            end else begin
                win_val_s = win_val_s;
            end
        end
    end

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: state_nxt_s = f_vld_s ? ST_SHOW : ST_IDLE;
            ST_SHOW: state_nxt_s = (rearb_s && !f_vld_s) ? ST_IDLE : ST_SHOW;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, dwell counter and pointer.
    always_comb begin
        owner_nxt_s = owner_r;
        cnt_nxt_s   = cnt_r;
        hex_nxt_s   = hex_r;
        mode_nxt_s  = mode_r;
        gnt_nxt_s   = gnt_r;
        ack_nxt_s   = 1'b0;
        if (f_vld_s && ((state_r == ST_IDLE) || (state_r == ST_SHOW && rearb_s))) begin
            owner_nxt_s = win_idx_s;
            cnt_nxt_s   = '0;
            hex_nxt_s   = win_val_s;
            mode_nxt_s  = MODE_HEX;
            gnt_nxt_s   = win_gnt_s;
            ack_nxt_s   = 1'b1;
        end else if (state_r == ST_SHOW && !rearb_s) begin
            cnt_nxt_s   = cnt_r + CNT_W'(1);
        end else begin
            // Idle or falling idle: blank, but keep OWNER as the round-robin pointer.
            cnt_nxt_s   = '0;
            hex_nxt_s   = 32'd0;
            mode_nxt_s  = MODE_OFF;
            gnt_nxt_s   = '0;
        end
    end

    // Output and datapath registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            owner_r <= 3'(NREQ - 1);
            cnt_r   <= '0;
            hex_r   <= 32'd0;
            mode_r  <= MODE_OFF;
            gnt_r   <= '0;
            ack_r   <= 1'b0;
        end else begin
            owner_r <= owner_nxt_s;
            cnt_r   <= cnt_nxt_s;
            hex_r   <= hex_nxt_s;
            mode_r  <= mode_nxt_s;
            gnt_r   <= gnt_nxt_s;
            ack_r   <= ack_nxt_s;
        end
    end

    assign HEX          = hex_r;
    assign display_mode = mode_r;
    assign GNT          = gnt_r;
    assign OWNER        = owner_r;
    assign ACK          = ack_r;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Bench for seg_display_arbiter: directed scenarios plus random traffic, all
// checked every cycle against a behavioural model of the arbitration rules.
module tb_seg_display_arbiter;

    localparam int NREQ  = 4;
    localparam int CNT_W = 27;
    localparam int DWELL = 4;

    logic              CLK = 1'b0;
    logic              RST_N = 1'b1;
    logic [NREQ-1:0]   REQ = '0;
    logic [NREQ-1:0]   URG = '0;
    logic [32*NREQ-1:0] VAL = '0;
    logic [31:0]       HEX;
    logic              display_mode;
    logic [NREQ-1:0]   GNT;
    logic [2:0]        OWNER;
    logic              ACK;

    int n_cmp = 0;
    int n_mis = 0;
    bit chk_en = 1'b0;

    seg_display_arbiter #(.NREQ(NREQ), .CNT_W(CNT_W), .DWELL(DWELL)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .REQ          (REQ),
        .URG          (URG),
        .VAL          (VAL),
        .HEX          (HEX),
        .display_mode (display_mode),
        .GNT          (GNT),
        .OWNER        (OWNER),
        .ACK          (ACK)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        show;
        logic [2:0]  owner;
        logic [31:0] cnt;
        logic [31:0] hex;
        logic        mode;
        logic [3:0]  gnt;
        logic        ack;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r.show  = 1'b0;
        r.owner = 3'(NREQ - 1);
        r.cnt   = 32'd0;
        r.hex   = 32'd0;
        r.mode  = 1'b0;
        r.gnt   = 4'd0;
        r.ack   = 1'b0;
        return r;
    endfunction

    // First set bit of mask searching from ptr+1 upward, modulo NREQ.
    function automatic int rr(input logic [3:0] mask, input int ptr);
        for (int k = 1; k <= NREQ; k++) begin
            int p;
            p = (ptr + k) % NREQ;
            if (mask[p]) return p;
        end
        return -1;
    endfunction

    function automatic model_t model_next(input model_t cur, input logic [3:0] req,
                                          input logic [3:0] urg, input logic [127:0] val);
        model_t n;
        int o, w;
        bit rearb, take, idle;
        logic [3:0] um;
        n = cur;
        n.ack = 1'b0;
        o = int'(cur.owner);
        um = req & urg;
        take = 1'b0;
        idle = 1'b0;
        if (!cur.show) begin
            take = (req != 4'd0);
        end else begin
            rearb = (int'(cur.cnt) == DWELL - 1) || !req[o] || (um != 4'd0 && !urg[o]);
            take = rearb && (req != 4'd0);
            idle = rearb && (req == 4'd0);
        end
        if (take) begin
            w = (um != 4'd0) ? rr(um, o) : rr(req, o);
            n.show  = 1'b1;
            n.owner = 3'(w);
            n.cnt   = 32'd0;
            n.hex   = val[32*w +: 32];
            n.mode  = 1'b1;
            n.gnt   = 4'(1 << w);
            n.ack   = 1'b1;
        end else if (idle) begin
            n.show = 1'b0;
            n.cnt  = 32'd0;
            n.hex  = 32'd0;
            n.mode = 1'b0;
            n.gnt  = 4'd0;
        end else if (cur.show) begin
            n.cnt = cur.cnt + 32'd1;
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model advances on the same edges as the design.
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) m <= model_reset();
        else        m <= model_next(m, REQ, URG, VAL);
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        if (chk_en) begin
            check("model_hex",   HEX, m.hex);
            check("model_mode",  32'(display_mode), 32'(m.mode));
            check("model_gnt",   32'(GNT), 32'(m.gnt));
            check("model_owner", 32'(OWNER), 32'(m.owner));
            check("model_ack",   32'(ACK), 32'(m.ack));
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    int acks;
    int own_exp;

    initial begin
        for (int i = 0; i < NREQ; i++) VAL[32*i +: 32] = 32'h1111_1111 * 32'(i + 1);
        REQ = 4'hF;
        #1 RST_N = 1'b0;
        #1 chk_en = 1'b1;
        tick();
        tick();
        check("rst_hex",  HEX, 32'd0);
        check("rst_mode", 32'(display_mode), 32'd0);
        check("rst_gnt",  32'(GNT), 32'd0);
        check("rst_ack",  32'(ACK), 32'd0);
        check("rst_owner", 32'(OWNER), 32'd3);

        // First grant after release searches from index 0.
        REQ = 4'b0101;
        RST_N = 1'b1;
        tick();
        check("first_gnt",   32'(GNT), 32'h1);
        check("first_owner", 32'(OWNER), 32'd0);
        check("first_hex",   HEX, 32'h1111_1111);
        check("first_ack",   32'(ACK), 32'd1);

        // Rotation with all requesters active.
        REQ = 4'hF;
        acks = 0;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (ACK) begin
                own_exp = (acks + 1) % NREQ;
                check("rot_tick",  32'(t % DWELL), 32'd0);
                check("rot_owner", 32'(OWNER), 32'(own_exp));
                check("rot_hex",   HEX, 32'h1111_1111 * 32'(own_exp + 1));
                acks++;
            end
        end
        check("rot_acks", 32'(acks), 32'd5);

        // Single requester: VAL change is invisible until the next relatch.
        REQ = 4'b0100;
        tick();
        check("single_owner", 32'(OWNER), 32'd2);
        check("single_hex0",  HEX, 32'h3333_3333);
        tick();
        VAL[64 +: 32] = 32'hDEAD_BEEF;
        tick();
        check("single_hold", HEX, 32'h3333_3333);
        tick();
        check("single_hold_ack", 32'(ACK), 32'd0);
        tick();
        check("single_relatch_ack", 32'(ACK), 32'd1);
        check("single_relatch_hex", HEX, 32'hDEAD_BEEF);
        check("single_relatch_own", 32'(OWNER), 32'd2);

        // Urgent preemption of a non-urgent owner, no preemption of an urgent one.
        REQ = 4'b0001;
        tick();
        check("pre_owner0", 32'(OWNER), 32'd0);
        tick();
        REQ = 4'b1001;
        URG = 4'b1000;
        tick();
        check("pre_gnt3", 32'(GNT), 32'b1000);
        check("pre_ack",  32'(ACK), 32'd1);
        check("pre_hex",  HEX, 32'h4444_4444);
        REQ = 4'b1011;
        URG = 4'b1010;
        for (int t = 0; t < DWELL - 1; t++) begin
            tick();
            check("pre_hold3", 32'(GNT), 32'b1000);
        end
        tick();
        check("pre_expire_gnt", 32'(GNT), 32'b0010);
        check("pre_expire_ack", 32'(ACK), 32'd1);

        // Drop to idle, then resume searching after the remembered owner.
        REQ = 4'b0000;
        URG = 4'b0000;
        tick();
        check("idle_mode",  32'(display_mode), 32'd0);
        check("idle_hex",   HEX, 32'd0);
        check("idle_gnt",   32'(GNT), 32'd0);
        check("idle_owner", 32'(OWNER), 32'd1);
        REQ = 4'b0011;
        tick();
        check("resume_gnt", 32'(GNT), 32'b0001);

        // Asynchronous reset between edges blanks immediately.
        #2 RST_N = 1'b0;
        #1;
        check("arst_hex",  HEX, 32'd0);
        check("arst_mode", 32'(display_mode), 32'd0);
        check("arst_gnt",  32'(GNT), 32'd0);
        REQ = 4'b0000;
        RST_N = 1'b1;
        tick();
        check("arst_noack1", 32'(ACK), 32'd0);
        tick();
        check("arst_noack2", 32'(ACK), 32'd0);
        REQ = 4'b0010;
        tick();
        check("arst_regnt", 32'(GNT), 32'b0010);
        check("arst_ack",   32'(ACK), 32'd1);

        // Random traffic against the model.
        for (int t = 0; t < 600; t++) begin
            if ($urandom_range(3) == 0) REQ = 4'($urandom);
            if ($urandom_range(4) == 0) URG = 4'($urandom & $urandom);
            if ($urandom_range(2) == 0) VAL[32*$urandom_range(NREQ - 1) +: 32] = $urandom;
            tick();
        end

        @(negedge CLK);
        #1 chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/seg_display_arbiter.md
# seg_display_arbiter

Time-shares the 8-digit seven-segment display between up to NREQ requesters. It drives the display block's 32-bit HEX word and display_mode bit, and sits directly upstream of the display driver. It grants the display round-robin, one owner at a time, for a programmable dwell period. Urgent requesters preempt non-urgent owners. Each requester's value is latched at grant so the display stays stable for the whole dwell.

## Interface
- NREQ, 4: number of requesters (2..8)
- CNT_W, 27: dwell counter width
- DWELL, 100_000_000: dwell length in CLK cycles (1 s at 100 MHz); must be ≥2 and < 2^CNT_W
- CLK  in  1  system clock, all logic on rising edge
- RST_N  in  1  reset, asynchronous, active-low
- REQ  in  NREQ  per-requester "want display" level
- URG  in  NREQ  per-requester urgent flag; ignored unless matching REQ bit is high
- VAL  in  32*NREQ  per-requester display word; requester i owns VAL[32*i+31:32*i]
- HEX  out  32  word to display driver, registered
- display_mode  out  1  1 = show HEX, 0 = display off, registered
- GNT  out  NREQ  one-hot current owner, all-zero when idle
- OWNER  out  3  binary index of current owner
- ACK  out  1  one-cycle pulse on every latch of a VAL word, including a re-grant to the same owner

## Operation
- Two states: IDLE and SHOW. Registers: state, OWNER, dwell counter cnt, HEX, display_mode, GNT, ACK.
- Round-robin pick over mask M: the first set bit of M searching from index OWNER+1 upward, wrapping modulo NREQ. The current owner is therefore picked last.
- Winner: rr(REQ & URG) if that set is non-zero, otherwise rr(REQ).
- In IDLE, if REQ ≠ 0 at a clock edge:
  - Grant the winner and latch its VAL into HEX.
  - Set display_mode=1, set GNT/OWNER to the winner, set cnt=0, pulse ACK.
  - Go to SHOW.
- In SHOW, re-arbitration (rearb) is triggered by any of:
  - (a) expiry: cnt == DWELL-1;
  - (b) REQ[OWNER] == 0;
  - (c) (REQ & URG) ≠ 0 and URG[OWNER] == 0.
- On rearb:
  - If REQ ≠ 0: grant the winner, relatch VAL, cnt=0, pulse ACK. The winner may be the same owner when it is the only requester.
  - If REQ == 0: go to IDLE, with HEX=0, display_mode=0, GNT=0. OWNER keeps its value as the round-robin pointer.
- In SHOW without rearb: cnt increments, all other registers hold. A change in VAL of the owner is not reflected until the next grant.
- An urgent owner is never preempted by another urgent requester; it yields only on expiry or on dropping REQ.
- Simultaneous expiry and preemption are handled as a single rearb; there is no double grant.
- URG bits with REQ low have no effect.

## Timing
- Reset (asynchronous, RST_N low):
  - State=IDLE, HEX=0, display_mode=0, GNT=0, ACK=0, cnt=0.
  - OWNER=NREQ-1, so the first grant searches from index 0.
- Reset mid-SHOW blanks the display immediately, without waiting for a clock edge.
- Grant latency: REQ sampled at edge k → GNT, HEX, display_mode and ACK are valid after edge k (1 cycle).
- Dwell: a grant at edge k with no interruption re-arbitrates at edge k+DWELL. The owner holds the display for exactly DWELL cycles.
- Preemption and drop latency: the condition is sampled at edge k and the new owner takes effect after edge k.
- ACK is high for exactly one cycle per latch. Back-to-back grants give ACK high on consecutive cycles.
- There is no blank cycle between owners; HEX switches in a single cycle.

## Structure
- Shared package seg_ctrl_pkg holds:
  - state encoding localparams (ST_IDLE, ST_SHOW);
  - display_mode encodings (MODE_OFF=0, MODE_HEX=1);
  - the default DWELL constant.
- One sub-module, rr_pick:
  - Combinational; inputs are mask[NREQ] and ptr[3]; outputs are a one-hot grant, a binary index, and a valid flag.
  - Instantiated twice: once for the urgent mask, once for the full mask.

## Test plan
Run with NREQ=4, DWELL=4.
- **Reset:** hold RST_N=0 with REQ=4'hF → HEX=0, display_mode=0, GNT=0, ACK=0. Release; the first edge with REQ=4'b0101 gives GNT=4'b0001, OWNER=0, HEX=VAL0, ACK pulse.
- **Rotation:** REQ=4'b1111 held, VALi=32'h1111_1111*(i+1) → owners 0,1,2,3,0 each for exactly 4 cycles, HEX tracking each VALi, one ACK per grant.
- **Single requester:** REQ=4'b0100, VAL2 changes mid-dwell → HEX keeps the old value until cnt wraps, then relatches to the new value, with ACK on each 4-cycle boundary and OWNER=2 throughout.
- **Preemption:** owner 0 at cnt=1; assert REQ[3]=URG[3]=1 → the next edge grants owner 3, cnt=0, ACK. A later URG[1]=REQ[1]=1 does not preempt owner 3 before its expiry.
- **Drop and idle:** owner 1 drops REQ with no other requesters → the next edge shows display_mode=0, HEX=0, GNT=0. A subsequent REQ=4'b0011 grants index 0 (search from 2, wrapping).
- **Async reset mid-SHOW:** pulse RST_N low between edges → outputs clear immediately, with no ACK after release until a REQ is sampled.
